// File: rtl/bus_addr_decoder.sv
// Pipelined Wishbone 1-to-N address decoder.
// Routes responses back in order and terminates unmapped accesses with an error.
module bus_addr_decoder #(
    parameter int                       NUM_SLAVES      = 2,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE      = {32'h4000_0000, 32'h8000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK      = {32'hFFFF_FFF0, 32'hC000_0000},
    parameter int                       MAX_OUTSTANDING = 4,
    parameter int                       DW              = 32
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     m_cyc_i,
    input  logic                     m_stb_i,
    input  logic                     m_we_i,
    input  logic [31:0]              m_addr_i,
    input  logic [DW-1:0]            m_wdata_i,
    input  logic [DW/8-1:0]          m_sel_i,
    output logic                     m_stall_o,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic [DW-1:0]            m_rdata_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [31:0]              s_addr_o,
    output logic [DW-1:0]            s_wdata_o,
    output logic [DW/8-1:0]          s_sel_o,
    input  logic [NUM_SLAVES-1:0]    s_stall_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES-1:0]    s_err_i,
    input  logic [NUM_SLAVES*DW-1:0] s_rdata_i
);

    // Target index NUM_SLAVES is the internal error target.
    localparam int TW = $clog2(NUM_SLAVES + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TW-1:0] ERR_TGT = TW'(NUM_SLAVES);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [TW-1:0] tgt_q, tgt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_pend_q, err_pend_d;

    logic [TW-1:0] dec;
    logic          dec_real;
    logic          tgt_real;
    logic          cnt_nz;
    logic          req;
    logic          accept;
    logic          stall;
    logic          switch_blk;
    logic          full_blk;
    logic          sel_ack;
    logic          sel_err;
    logic          sel_stall;
    logic [DW-1:0] sel_rdata;
    logic          resp_real;
    logic          resp;

    // Address decode: scan downwards so the lowest matching region wins.
    always_comb begin
        dec = ERR_TGT;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                dec = TW'(i);
            end
        end
    end

    // Select response lines of the owning slave and stall of the decoded one.
    always_comb begin
        sel_ack   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        sel_stall = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (tgt_q == TW'(i)) begin
                sel_ack   = s_ack_i[i];
                sel_err   = s_err_i[i];
                sel_rdata = s_rdata_i[DW*i +: DW];
            end
            if (dec == TW'(i)) begin
                sel_stall = s_stall_i[i];
            end
        end
    end

    assign dec_real   = (dec != ERR_TGT);
    assign tgt_real   = (tgt_q != ERR_TGT);
    assign cnt_nz     = (cnt_q != '0);
    assign req        = m_cyc_i & m_stb_i;

    // Pending responses pin the target so replies come back in order.
    assign switch_blk = cnt_nz & (dec != tgt_q);
    assign resp_real  = tgt_real & cnt_nz & (sel_ack | sel_err);
    assign resp       = resp_real | err_pend_q;
    assign full_blk   = (cnt_q == CNT_MAX) & ~resp;

    assign stall  = ~rstn_i
                  | (req & (switch_blk | full_blk | (dec_real & sel_stall)));
    assign accept = rstn_i & req & ~stall;

    // Slave-side strobes and cycles, all forced low during reset.
    always_comb begin
        s_stb_o = '0;
        s_cyc_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_stb_o[i] = rstn_i & req & ~switch_blk & ~full_blk
                       & (dec == TW'(i));
            s_cyc_o[i] = rstn_i & m_cyc_i
                       & ((cnt_nz & (tgt_q == TW'(i))) | (req & (dec == TW'(i))));
        end
    end

    assign s_we_o    = m_we_i;
    assign s_addr_o  = m_addr_i;
    assign s_wdata_o = m_wdata_i;
    assign s_sel_o   = m_sel_i;

    assign m_stall_o = stall;
    assign m_ack_o   = rstn_i & tgt_real & cnt_nz & sel_ack;
    assign m_err_o   = rstn_i & ((tgt_real & cnt_nz & sel_err) | err_pend_q);
    assign m_rdata_o = (rstn_i & resp_real) ? sel_rdata : '0;

    // Next-state: target latch, outstanding count, error-target reply.
    always_comb begin
        tgt_d      = tgt_q;
        cnt_d      = cnt_q;
        err_pend_d = 1'b0;
        if (accept) begin
            tgt_d = dec;
        end
        if (!m_cyc_i) begin
            cnt_d = '0;
        end else begin
            cnt_d      = cnt_q + CW'(accept) - CW'(resp);
            err_pend_d = accept & ~dec_real;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tgt_q      <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
        end else begin
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
        end
    end

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed testbench for bus_addr_decoder.
// Each task drives one scenario and checks outputs between clock edges.
module tb_bus_addr_decoder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_sel;
    logic        m_stall, m_ack, m_err;
    logic [31:0] m_rdata;
    logic [1:0]  s_cyc, s_stb;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_sel;
    logic [1:0]  s_stall, s_ack, s_err;
    logic [63:0] s_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_addr_decoder dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_sel_i   (m_sel),
        .m_stall_o (m_stall),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .m_rdata_o (m_rdata),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_sel_o   (s_sel),
        .s_stall_i (s_stall),
        .s_ack_i   (s_ack),
        .s_err_i   (s_err),
        .s_rdata_i (s_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_sel = '0;
        s_stall = '0; s_ack = '0; s_err = '0; s_rdata = '0;
        tick(); tick();
        m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h8000_0000;
        #1;
        checks++; if (m_stall !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b exp 1", m_stall); end
        checks++; if (s_stb !== 2'b00) begin errors++; $display("FAIL rst_stb: got %b exp 00", s_stb); end
        checks++; if (s_cyc !== 2'b00) begin errors++; $display("FAIL rst_cyc: got %b exp 00", s_cyc); end
        checks++; if ({m_ack, m_err} !== 2'b00) begin errors++; $display("FAIL rst_ackerr: got %b exp 00", {m_ack, m_err}); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", m_rdata); end
        m_cyc = 1'b0; m_stb = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0;
        m_addr = 32'h8000_0010; m_sel = 4'hF;
        #1;
        checks++; if (s_stb !== 2'b01) begin errors++; $display("FAIL rd_stb: got %b exp 01", s_stb); end
        checks++; if (m_stall !== 1'b0) begin errors++; $display("FAIL rd_stall: got %b exp 0", m_stall); end
        checks++; if ({s_addr, s_sel, s_we} !== {32'h8000_0010, 4'hF, 1'b0}) begin errors++; $display("FAIL rd_bcast: got %h %h %b", s_addr, s_sel, s_we); end
        tick();
        m_stb = 1'b0;
        #1;
        checks++; if (s_cyc !== 2'b01) begin errors++; $display("FAIL rd_cyc_hold: got %b exp 01", s_cyc); end
        checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_early: got %b exp 0", m_ack); end
        tick();
        s_ack = 2'b01; s_rdata = {32'h0, 32'hDEAD_BEEF};
        #1;
        checks++; if (m_ack !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b exp 1", m_ack); end
        checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h exp deadbeef", m_rdata); end
        tick();
        s_ack = 2'b00; s_rdata = '0;
        #1;
        checks++; if (s_cyc !== 2'b00) begin errors++; $display("FAIL rd_idle: got %b exp 00", s_cyc); end
        checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_done: got %b exp 0", m_ack); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        m_cyc = 1'b1; m_stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 32'h4000_0000 + 32'(4 * k);
            m_addr = a;
            #1;
            checks++; if ({m_stall, s_stb} !== 3'b010) begin errors++; $display("FAIL b2b_acc%0d: got %b exp 010", k, {m_stall, s_stb}); end
            tick();
        end
        m_addr = 32'h4000_0004;
        #1;
        checks++; if ({m_stall, s_stb} !== 3'b100) begin errors++; $display("FAIL b2b_full: got %b exp 100", {m_stall, s_stb}); end
        tick();
        s_ack = 2'b10; s_rdata = {32'h1111_0000, 32'h0};
        #1;
        checks++; if ({m_ack, m_stall, s_stb} !== 4'b1010) begin errors++; $display("FAIL b2b_ackacc: got %b exp 1010", {m_ack, m_stall, s_stb}); end
        checks++; if (m_rdata !== 32'h1111_0000) begin errors++; $display("FAIL b2b_rdata: got %h exp 11110000", m_rdata); end
        tick();
        m_stb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_rdata = {32'(k + 1), 32'h0};
            #1;
            checks++; if ({m_ack, m_rdata} !== {1'b1, 32'(k + 1)}) begin errors++; $display("FAIL b2b_drain%0d: got %b %h", k, m_ack, m_rdata); end
            tick();
        end
        s_ack = 2'b00; s_rdata = '0;
        #1;
        checks++; if ({s_cyc, m_ack} !== 3'b000) begin errors++; $display("FAIL b2b_idle: got %b exp 000", {s_cyc, m_ack}); end
    endtask

    task automatic test_switch_block();
        m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h4000_0000;
        tick();
        m_addr = 32'h8000_0000;
        #1;
        checks++; if ({m_stall, s_stb, s_cyc} !== 5'b10011) begin errors++; $display("FAIL sw_block: got %b exp 10011", {m_stall, s_stb, s_cyc}); end
        tick();
        #1;
        checks++; if (m_stall !== 1'b1) begin errors++; $display("FAIL sw_block2: got %b exp 1", m_stall); end
        tick();
        s_ack = 2'b10;
        #1;
        checks++; if ({m_ack, m_stall} !== 2'b11) begin errors++; $display("FAIL sw_ack: got %b exp 11", {m_ack, m_stall}); end
        tick();
        s_ack = 2'b00;
        #1;
        checks++; if ({m_stall, s_stb} !== 3'b001) begin errors++; $display("FAIL sw_go: got %b exp 001", {m_stall, s_stb}); end
        tick();
        m_stb = 1'b0; s_ack = 2'b01; s_rdata = {32'h0, 32'h0000_5A5A};
        #1;
        checks++; if ({m_ack, m_rdata} !== {1'b1, 32'h0000_5A5A}) begin errors++; $display("FAIL sw_ack0: got %b %h", m_ack, m_rdata); end
        tick();
        s_ack = 2'b00; s_rdata = '0;
    endtask

    task automatic test_unmapped();
        m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h0000_1000;
        #1;
        checks++; if ({m_stall, s_stb, s_cyc, m_err} !== 6'b000000) begin errors++; $display("FAIL um_acc1: got %b exp 000000", {m_stall, s_stb, s_cyc, m_err}); end
        tick();
        #1;
        checks++; if ({m_err, m_ack, m_stall, s_stb} !== 5'b10000) begin errors++; $display("FAIL um_err1: got %b exp 10000", {m_err, m_ack, m_stall, s_stb}); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL um_rdata: got %h exp 0", m_rdata); end
        tick();
        m_stb = 1'b0;
        #1;
        checks++; if ({m_err, m_ack} !== 2'b10) begin errors++; $display("FAIL um_err2: got %b exp 10", {m_err, m_ack}); end
        tick();
        #1;
        checks++; if ({m_err, s_cyc} !== 3'b000) begin errors++; $display("FAIL um_done: got %b exp 000", {m_err, s_cyc}); end
    endtask

    task automatic test_spurious_abort();
        m_cyc = 1'b1; m_stb = 1'b0; s_ack = 2'b01; s_rdata = {32'h0, 32'h1234_5678};
        #1;
        checks++; if ({m_ack, m_rdata} !== {1'b0, 32'h0}) begin errors++; $display("FAIL sp_idle: got %b %h", m_ack, m_rdata); end
        tick();
        s_ack = 2'b00; s_rdata = '0;
        m_stb = 1'b1; m_addr = 32'h8000_0000;
        tick();
        m_addr = 32'h8000_0004;
        tick();
        m_cyc = 1'b0; m_stb = 1'b0;
        #1;
        checks++; if (s_cyc !== 2'b00) begin errors++; $display("FAIL ab_cyc: got %b exp 00", s_cyc); end
        tick();
        s_ack = 2'b01;
        #1;
        checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL ab_late1: got %b exp 0", m_ack); end
        tick();
        m_cyc = 1'b1;
        #1;
        checks++; if ({m_ack, s_cyc} !== 3'b000) begin errors++; $display("FAIL ab_late2: got %b exp 000", {m_ack, s_cyc}); end
        tick();
        s_ack = 2'b00;
    endtask

    task automatic test_reset_mid();
        m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h8000_0000;
        tick(); tick(); tick();
        #2;
        rstn = 1'b0;
        s_ack = 2'b01; s_rdata = {32'h0, 32'hCAFE_0001};
        #1;
        checks++; if ({s_cyc, s_stb} !== 4'b0000) begin errors++; $display("FAIL mr_slv: got %b exp 0000", {s_cyc, s_stb}); end
        checks++; if ({m_stall, m_ack, m_err} !== 3'b100) begin errors++; $display("FAIL mr_mst: got %b exp 100", {m_stall, m_ack, m_err}); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL mr_rdata: got %h exp 0", m_rdata); end
        m_cyc = 1'b0; m_stb = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL mr_noresp: got %b exp 0", m_ack); end
        tick();
        s_ack = 2'b00; s_rdata = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        tick();
        test_back_to_back();
        tick();
        test_switch_block();
        tick();
        test_unmapped();
        tick();
        test_spurious_abort();
        tick();
        test_reset_mid();
        test_single_read();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_addr_decoder.md
Name: bus_addr_decoder

Overview:
- Parametrised 1-master to NUM_SLAVES-slave pipelined Wishbone decoder. It generalises the fixed platform address map (DMEM at 0x8000_0000 with mask 0xC000_0000, MTIMER at 0x4000_0000 with mask 0xFFFF_FFF0) to N base/mask regions.
- Sits between the core data port and the platform memories and peripherals.
- Tracks outstanding transactions so each response is routed back from the slave that owns it.
- Terminates unmapped accesses with a bus error.

Parameters:
- NUM_SLAVES, 2, number of decoded regions.
- SLAVE_BASE, {32'h4000_0000, 32'h8000_0000}, packed NUM_SLAVES*32 base addresses; slave i occupies bits [32i+31:32i].
- SLAVE_MASK, {32'hFFFF_FFF0, 32'hC000_0000}, packed NUM_SLAVES*32 masks, same layout.
- MAX_OUTSTANDING, 4, maximum accepted requests awaiting a response; must be >= 1.
- DW, 32, data width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- m_cyc_i, m_stb_i, m_we_i  in  1 each  master cycle, strobe and write enable.
- m_addr_i  in  32  master address.
- m_wdata_i  in  DW  master write data.
- m_sel_i  in  DW/8  master byte selects.
- m_stall_o, m_ack_o, m_err_o  out  1 each  master stall, ack and error.
- m_rdata_o  out  DW  master read data.
- s_cyc_o, s_stb_o  out  NUM_SLAVES each  per-slave cycle and strobe.
- s_we_o  out  1  broadcast write enable.
- s_addr_o  out  32  broadcast address.
- s_wdata_o  out  DW  broadcast write data.
- s_sel_o  out  DW/8  broadcast byte selects.
- s_stall_i, s_ack_i, s_err_i  in  NUM_SLAVES each  per-slave stall, ack and error.
- s_rdata_i  in  NUM_SLAVES*DW  per-slave read data, same packing as SLAVE_BASE.

Behaviour:
- Decode (combinational):
  - hit[i] = ((m_addr_i & SLAVE_MASK[i]) == SLAVE_BASE[i]).
  - Lowest matching index wins.
  - No match selects the internal error target, index NUM_SLAVES.
- State:
  - tgt: current target index, 0..NUM_SLAVES.
  - cnt: outstanding count, clog2(MAX_OUTSTANDING+1) bits.
  - err_pend: 1 bit.
- Reset, asynchronous on rstn_i low: cnt=0, tgt=0, err_pend=0. Outputs while in reset: all s_cyc_o/s_stb_o=0, m_ack_o=0, m_err_o=0, m_rdata_o=0, m_stall_o=1.
- req = m_cyc_i & m_stb_i. accept = req & ~m_stall_o.
- m_stall_o asserts when req and any of the following holds:
  - cnt!=0 and decoded target != tgt. No target switch while responses are pending; this guarantees in-order routing.
  - cnt==MAX_OUTSTANDING and no response this cycle.
  - the decoded target is a real slave with its s_stall_i set.
- s_stb_o[d] = req & no-switch-block & cnt-limit-ok, where d is the decoded slave. A slave may stall via s_stall_i. The error target never stalls.
- s_cyc_o[i] = m_cyc_i & ((cnt!=0 & tgt==i) | (req & d==i)).
- Broadcast signals are m_* passed through combinationally.
- On accept: tgt <= d.
- resp:
  - Real target: resp = (s_ack_i[tgt] | s_err_i[tgt]) & cnt!=0. m_ack_o, m_err_o and m_rdata_o are taken from slave tgt in the same cycle, with zero added latency.
  - Error target: err_pend <= accept & d==NUM_SLAVES. m_err_o = err_pend. m_rdata_o = 0. Exactly 1-cycle latency; back-to-back unmapped accesses error on consecutive cycles.
- Counter: cnt <= cnt + accept - resp. A simultaneous accept and resp leaves cnt unchanged. cnt never exceeds MAX_OUTSTANDING and never underflows.
- Ignored responses:
  - Acks or errors from non-tgt slaves are ignored.
  - Any ack or error while cnt==0 is ignored. m_ack_o stays 0.
- Abort: when m_cyc_i drops, next cycle cnt=0 and err_pend=0. All s_cyc_o drop combinationally. Late slave responses are ignored per the rule above.
- Reset mid-transaction: state clears immediately; no response is delivered afterwards.

Test Plan:
- Read at 0x8000_0010. Slave0 acks after 2 cycles with rdata 0xDEAD_BEEF. Required: s_stb_o=2'b01, m_ack_o=1 with m_rdata_o=0xDEAD_BEEF, cnt returns to 0.
- Four back-to-back reads at 0x4000_0000..0x4000_000C with slave1 delaying acks. Required: 4 accepts, no stall. A fifth request stalls until the first ack, and the accept occurs in the same cycle as that ack.
- Read at 0x4000_0000 still pending, then a request to 0x8000_0000. Required: m_stall_o=1 until the slave1 ack, then the request goes to slave0.
- Two consecutive requests to 0x0000_1000 (unmapped). Required: no s_stb_o, m_err_o=1 exactly one cycle after each accept, m_rdata_o=0.
- Spurious s_ack_i[0] while idle, and m_cyc_i dropped with 2 requests outstanding followed by late acks. Required: m_ack_o stays 0, cnt=0.
- rstn_i pulsed low with cnt=3. Required: all outputs reset asynchronously, and the next transaction behaves as the first scenario.
